one_wire_byte_sender: RTL and testbench
=======================================

ONE_WIRE_BYTE_SENDER -- requirements
Module: one_wire_byte_sender

Interface
REQ-001 SHALL have parameter CLKS_PER_US, default 50, meaning clk cycles per microsecond (range 2..255).
REQ-002 SHALL have parameter FETCH_TIMEOUT, default 15, meaning max clk cycles from read_en rise to data_dv.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to send a frame.
REQ-006 SHALL have port byte_count  input  6  number of buffer bytes to send, 0..32; sampled with start.
REQ-007 SHALL have port read_address  output  5  byte-buffer read address.
REQ-008 SHALL have port read_en  output  1  byte-buffer read request.
REQ-009 SHALL have port data_out  input  8  byte returned by buffer.
REQ-010 SHALL have port data_dv  input  1  data_out valid strobe from buffer.
REQ-011 SHALL have port ow_in  input  1  asynchronous 1-wire line level.
REQ-012 SHALL have port ow_drive_low  output  1  1 = pull line low (open-drain enable); 0 = release.
REQ-013 SHALL have port busy  output  1  high from accepted start until done.
REQ-014 SHALL have port done  output  1  one-cycle pulse at frame end (success or abort).
REQ-015 SHALL have port presence_err  output  1  no presence pulse detected; sticky until next accepted start.
REQ-016 SHALL have port fetch_err  output  1  buffer fetch timed out; sticky until next accepted start.

Function
REQ-017 SHALL double-flop ow_in (flops reset to 1); all line sampling uses synchronized value.
REQ-018 SHALL derive a 1 us tick from a prescaler counting 0..CLKS_PER_US-1, restarted on every state entry; a 9-bit us counter times each phase.
REQ-019 SHALL implement states IDLE, RST_LOW, RST_REL, FETCH, SLOT_LOW, SLOT_REC, FINISH.
REQ-020 IDLE: start=1 -> latch byte_count, clear both error flags, byte index=0, busy=1, go RST_LOW; start while busy SHALL be ignored.
REQ-021 RST_LOW: ow_drive_low=1 for 480 us, then RST_REL.
REQ-022 RST_REL: release line; sample synchronized line at 70 us after entry; 0 = presence; total 480 us in state.
REQ-023 End of RST_REL: no presence -> presence_err=1, go FINISH; presence and byte_count=0 -> FINISH; else FETCH.
REQ-024 FETCH: read_address = byte index, stable for the whole state; read_en=1 from entry until the cycle data_dv=1 is seen, then read_en=0 next cycle.
REQ-025 FETCH: data_dv=1 -> capture data_out into shift register, bit index=0, go SLOT_LOW.
REQ-026 FETCH: no data_dv within FETCH_TIMEOUT cycles -> read_en=0, fetch_err=1, go FINISH.
REQ-027 SLOT_LOW: ow_drive_low=1 for 6 us if current bit=1, 60 us if bit=0; then SLOT_REC.
REQ-028 SLOT_REC: release line until slot total = 70 us (64 us after 1-bit, 10 us after 0-bit).
REQ-029 Bits SHALL be sent LSB first; after bit 7 increment byte index; index = latched count -> FINISH, else FETCH.
REQ-030 FINISH: done=1 for exactly one cycle, busy=0 in same cycle, go IDLE.
REQ-031 data_dv outside FETCH SHALL be ignored.
REQ-032 ow_drive_low SHALL be 1 only in RST_LOW and SLOT_LOW; a registered output, glitch-free.
REQ-033 Byte index SHALL be 6 bits; read_address = its low 5 bits (count 32 reads addresses 0..31, no wrap within frame).

Reset
REQ-034 reset=1 SHALL, on next edge, force IDLE and all outputs to 0 (read_address=0, ow_drive_low=0), clear error flags and counters.
REQ-035 reset mid-frame SHALL release the line immediately on that edge and produce no done pulse.

Verification
REQ-036 CLKS_PER_US=2, byte_count=1, buffer[0]=8'hA5, presence at 70 us -> 480 us low, 480 us release, one fetch of addr 0, 8 slots bits 1,0,1,0,0,1,0,1 (low 6/60 us, 70 us period), one done, no errors.
REQ-037 ow_in held 1 during RST_REL -> presence_err=1, done pulse at 960 us, read_en never asserted.
REQ-038 byte_count=3, buffer 8'h00,8'hFF,8'h01 -> addresses 0,1,2 fetched in order, 24 slots, read_en dropped after each data_dv.
REQ-039 data_dv never asserted -> read_en high 15 cycles, fetch_err=1, done pulse, line released.
REQ-040 reset asserted during a 60 us SLOT_LOW -> ow_drive_low=0 next edge, busy=0, no done; new start afterwards runs full frame.
REQ-041 start pulsed while busy, and byte_count=0 with presence -> second start ignored; zero-count frame ends with done after reset phase, no fetch.

Source files
------------

// File: rtl/one_wire_byte_sender.sv
`default_nettype none
// ============================================================================
// Module      : one_wire_byte_sender
// Description : 1-wire master that sends a reset/presence sequence followed by
//               a frame of bytes fetched one at a time from a byte buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module one_wire_byte_sender #(
  parameter int CLKS_PER_US   = 50,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] byte_count,
  output logic [4:0] read_address,
  output logic       read_en,
  input  logic [7:0] data_out,
  input  logic       data_dv,
  input  logic       ow_in,
  output logic       ow_drive_low,
  output logic       busy,
  output logic       done,
  output logic       presence_err,
  output logic       fetch_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_LOW  = 3'd1,
    RST_REL  = 3'd2,
    FETCH    = 3'd3,
    SLOT_LOW = 3'd4,
    SLOT_REC = 3'd5,
    FINISH   = 3'd6
  } state_t;

  // Phase end values are "last microsecond index" of the us counter.
  localparam logic [7:0]  c_presc_last    = 8'(CLKS_PER_US - 1);
  localparam logic [15:0] c_fetch_last    = 16'(FETCH_TIMEOUT - 1);
  localparam logic [8:0]  c_rst_last      = 9'd479;
  localparam logic [8:0]  c_presence_at   = 9'd69;
  localparam logic [8:0]  c_low_one_last  = 9'd5;
  localparam logic [8:0]  c_low_zero_last = 9'd59;
  localparam logic [8:0]  c_rec_one_last  = 9'd63;
  localparam logic [8:0]  c_rec_zero_last = 9'd9;

  state_t      r_state;
  logic [7:0]  r_presc;
  logic [8:0]  r_us;
  logic [15:0] r_fetch_cnt;
  logic [5:0]  r_count;
  logic [5:0]  r_idx;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_presence;
  logic        r_ow_meta;
  logic        r_ow_sync;

  logic        w_tick;
  logic [5:0]  w_idx_next;
  logic [8:0]  w_low_last;
  logic [8:0]  w_rec_last;

  assign w_tick       = (r_presc == c_presc_last);
  assign w_idx_next   = r_idx + 6'd1;
  assign w_low_last   = r_shift[0] ? c_low_one_last : c_low_zero_last;
  assign w_rec_last   = r_shift[0] ? c_rec_one_last : c_rec_zero_last;
  assign read_address = r_idx[4:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_presc      <= '0;
      r_us         <= '0;
      r_fetch_cnt  <= '0;
      r_count      <= '0;
      r_idx        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_presence   <= 1'b0;
      r_ow_meta    <= 1'b1;
      r_ow_sync    <= 1'b1;
      read_en      <= 1'b0;
      ow_drive_low <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      presence_err <= 1'b0;
      fetch_err    <= 1'b0;
    end else begin
      r_ow_meta <= ow_in;
      r_ow_sync <= r_ow_meta;
      done      <= 1'b0;

      // Free-running 1 us timebase; every state change below restarts it.
      if (w_tick) begin
        r_presc <= '0;
        r_us    <= r_us + 9'd1;
      end else begin
        r_presc <= r_presc + 8'd1;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_count      <= byte_count;
            r_idx        <= '0;
            r_presence   <= 1'b0;
            presence_err <= 1'b0;
            fetch_err    <= 1'b0;
            busy         <= 1'b1;
            ow_drive_low <= 1'b1;
            r_state      <= RST_LOW;
            r_presc      <= '0;
            r_us         <= '0;
          end
        end

        RST_LOW: begin
          if (w_tick && r_us == c_rst_last) begin
            ow_drive_low <= 1'b0;
            r_state      <= RST_REL;
            r_presc      <= '0;
            r_us         <= '0;
          end
        end

        RST_REL: begin
          if (w_tick && r_us == c_presence_at) begin
            r_presence <= ~r_ow_sync;
          end
          if (w_tick && r_us == c_rst_last) begin
            r_presc <= '0;
            r_us    <= '0;
            if (!r_presence) begin
              presence_err <= 1'b1;
              done         <= 1'b1;
              busy         <= 1'b0;
              r_state      <= FINISH;
            end else if (r_count == 6'd0) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= FINISH;
            end else begin
              read_en     <= 1'b1;
              r_fetch_cnt <= '0;
              r_state     <= FETCH;
            end
          end
        end

        FETCH: begin
          if (data_dv) begin
            r_shift      <= data_out;
            r_bit        <= '0;
            read_en      <= 1'b0;
            ow_drive_low <= 1'b1;
            r_state      <= SLOT_LOW;
            r_presc      <= '0;
            r_us         <= '0;
          end else if (r_fetch_cnt == c_fetch_last) begin
            read_en   <= 1'b0;
            fetch_err <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            r_state   <= FINISH;
            r_presc   <= '0;
            r_us      <= '0;
          end else begin
            r_fetch_cnt <= r_fetch_cnt + 16'd1;
          end
        end

        SLOT_LOW: begin
          if (w_tick && r_us == w_low_last) begin
            ow_drive_low <= 1'b0;
            r_state      <= SLOT_REC;
            r_presc      <= '0;
            r_us         <= '0;
          end
        end

        SLOT_REC: begin
          // Recovery pads every slot out to a 70 us period.
          if (w_tick && r_us == w_rec_last) begin
            r_presc <= '0;
            r_us    <= '0;
            if (r_bit == 3'd7) begin
              r_idx <= w_idx_next;
              if (w_idx_next == r_count) begin
                done    <= 1'b1;
                busy    <= 1'b0;
                r_state <= FINISH;
              end else begin
                read_en     <= 1'b1;
                r_fetch_cnt <= '0;
                r_state     <= FETCH;
              end
            end else begin
              r_bit        <= r_bit + 3'd1;
              r_shift      <= {1'b0, r_shift[7:1]};
              ow_drive_low <= 1'b1;
              r_state      <= SLOT_LOW;
            end
          end
        end

        FINISH: begin
          r_state <= IDLE;
          r_presc <= '0;
          r_us    <= '0;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_one_wire_byte_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_one_wire_byte_sender
// Description : Self-checking bench with a line/buffer model and waveform log.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_one_wire_byte_sender;

  localparam int C = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] byte_count = '0;
  logic [4:0] read_address;
  logic       read_en;
  logic [7:0] data_out = '0;
  logic       data_dv = 1'b0;
  logic       ow_in = 1'b1;
  logic       ow_drive_low;
  logic       busy;
  logic       done;
  logic       presence_err;
  logic       fetch_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rise_q[$], fall_q[$], low_q[$];
  int ren_rise_q[$], ren_fall_q[$], ren_len_q[$], addr_q[$], delay_q[$], done_q[$];
  int done_busy_bad = 0;
  int addr_unstable = 0;
  bit device_present = 1'b1;
  bit dv_enable = 1'b1;
  logic [7:0] mem [32];

  one_wire_byte_sender #(.CLKS_PER_US(C), .FETCH_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_count(byte_count),
    .read_address(read_address), .read_en(read_en), .data_out(data_out),
    .data_dv(data_dv), .ow_in(ow_in), .ow_drive_low(ow_drive_low),
    .busy(busy), .done(done), .presence_err(presence_err), .fetch_err(fetch_err)
  );

  initial forever #5 clk = ~clk;

  // Line model (open drain + slave presence pulse), buffer model and event log.
  initial begin : monitor
    int last_rise = 0;
    int ren_start = 0;
    int pres_s = -1;
    int pres_e = -1;
    int dly = -1;
    logic prev_drv = 1'b0;
    logic prev_ren = 1'b0;
    logic [4:0] ren_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (ow_drive_low && !prev_drv) begin
        rise_q.push_back(cyc);
        last_rise = cyc;
      end
      if (!ow_drive_low && prev_drv) begin
        fall_q.push_back(cyc);
        low_q.push_back(cyc - last_rise);
        if (cyc - last_rise >= 400 * C) begin
          pres_s = cyc + 15 * C;
          pres_e = cyc + 240 * C;
        end
      end
      if (read_en && !prev_ren) begin
        ren_rise_q.push_back(cyc);
        addr_q.push_back(int'(read_address));
        ren_addr  = read_address;
        ren_start = cyc;
      end
      if (read_en && read_address !== ren_addr) addr_unstable++;
      if (!read_en && prev_ren) begin
        ren_fall_q.push_back(cyc);
        ren_len_q.push_back(cyc - ren_start);
      end
      if (done === 1'b1) begin
        done_q.push_back(cyc);
        if (busy !== 1'b0) done_busy_bad++;
      end
      prev_drv = ow_drive_low;
      prev_ren = read_en;
      ow_in = !(ow_drive_low || (device_present && cyc >= pres_s && cyc < pres_e));
      data_dv = 1'b0;
      if (read_en && dv_enable) begin
        if (dly < 0) begin
          dly = int'($urandom_range(0, 4));
          delay_q.push_back(dly);
        end
        if (dly == 0) begin
          data_out = mem[read_address];
          data_dv  = 1'b1;
          dly      = -1;
        end else begin
          dly--;
        end
      end else begin
        dly = -1;
      end
    end
  end

  task automatic clear_logs();
    rise_q.delete(); fall_q.delete(); low_q.delete();
    ren_rise_q.delete(); ren_fall_q.delete(); ren_len_q.delete();
    addr_q.delete(); delay_q.delete(); done_q.delete();
    done_busy_bad = 0;
    addr_unstable = 0;
  endtask

  task automatic send_start(input int n);
    @(negedge clk);
    start = 1'b1;
    byte_count = 6'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_q.size() > 0) begin
        to = 1'b0;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({read_address, read_en, ow_drive_low, busy, done, presence_err, fetch_err} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {read_address, read_en, ow_drive_low, busy, done, presence_err, fetch_err});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Full frames: directed A5, 00/FF/01, 32-byte boundary, then random ones.
  task automatic test_frames();
    for (int f = 0; f < 5; f++) begin
      int n;
      bit to;
      int exp_low;
      int nxt;
      if (f == 0) begin
        n = 1; mem[0] = 8'hA5;
      end else if (f == 1) begin
        n = 3; mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h01;
      end else begin
        n = (f == 2) ? 32 : int'($urandom_range(1, 2));
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      end
      clear_logs();
      dv_enable = 1'b1;
      device_present = 1'b1;
      send_start(n);
      wait_done(960 * C + n * (560 * C + 20) + 200, to);
      n_cmp++;
      if (to || done_q.size() != 1) begin
        n_bad++;
        $display("FAIL frame%0d done_count: got %0d, expected 1", f, done_q.size());
      end
      n_cmp++;
      if (presence_err !== 1'b0 || fetch_err !== 1'b0 || busy !== 1'b0 || done_busy_bad != 0) begin
        n_bad++;
        $display("FAIL frame%0d flags: perr=%b ferr=%b busy=%b busy_at_done=%0d, expected 0 0 0 0",
                 f, presence_err, fetch_err, busy, done_busy_bad);
      end
      n_cmp++;
      if (addr_unstable != 0) begin
        n_bad++;
        $display("FAIL frame%0d addr_stable: got %0d changes, expected 0", f, addr_unstable);
      end
      n_cmp++;
      if (ren_rise_q.size() != n || ren_len_q.size() != n || delay_q.size() != n) begin
        n_bad++;
        $display("FAIL frame%0d fetch_count: got %0d, expected %0d", f, ren_rise_q.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          n_cmp++;
          if (addr_q[i] != i) begin
            n_bad++;
            $display("FAIL frame%0d fetch_addr[%0d]: got %0d, expected %0d", f, i, addr_q[i], i);
          end
          n_cmp++;
          if (ren_len_q[i] != delay_q[i] + 1) begin
            n_bad++;
            $display("FAIL frame%0d read_en_len[%0d]: got %0d, expected %0d", f, i, ren_len_q[i], delay_q[i] + 1);
          end
        end
      end
      n_cmp++;
      if (low_q.size() != 1 + 8 * n) begin
        n_bad++;
        $display("FAIL frame%0d low_pulses: got %0d, expected %0d", f, low_q.size(), 1 + 8 * n);
      end else if (ren_rise_q.size() == n && ren_fall_q.size() == n && done_q.size() == 1) begin
        n_cmp++;
        if (low_q[0] != 480 * C) begin
          n_bad++;
          $display("FAIL frame%0d reset_low: got %0d, expected %0d", f, low_q[0], 480 * C);
        end
        n_cmp++;
        if (ren_rise_q[0] - fall_q[0] != 480 * C) begin
          n_bad++;
          $display("FAIL frame%0d reset_release: got %0d, expected %0d", f, ren_rise_q[0] - fall_q[0], 480 * C);
        end
        for (int j = 0; j < 8 * n; j++) begin
          exp_low = mem[j / 8][j % 8] ? 6 * C : 60 * C;
          n_cmp++;
          if (low_q[1 + j] != exp_low) begin
            n_bad++;
            $display("FAIL frame%0d slot_low[%0d]: got %0d, expected %0d", f, j, low_q[1 + j], exp_low);
          end
          n_cmp++;
          if (j % 8 != 0 && rise_q[1 + j] - rise_q[j] != 70 * C) begin
            n_bad++;
            $display("FAIL frame%0d slot_period[%0d]: got %0d, expected %0d", f, j, rise_q[1 + j] - rise_q[j], 70 * C);
          end else if (j % 8 == 0 && rise_q[1 + j] != ren_fall_q[j / 8]) begin
            n_bad++;
            $display("FAIL frame%0d first_slot[%0d]: got %0d, expected %0d", f, j, rise_q[1 + j], ren_fall_q[j / 8]);
          end
          if (j % 8 == 7) begin
            nxt = (j / 8 == n - 1) ? done_q[0] : ren_rise_q[j / 8 + 1];
            n_cmp++;
            if (nxt - rise_q[1 + j] != 70 * C) begin
              n_bad++;
              $display("FAIL frame%0d last_slot_end[%0d]: got %0d, expected %0d", f, j, nxt - rise_q[1 + j], 70 * C);
            end
          end
        end
      end
    end
  endtask

  task automatic test_presence_err();
    bit to;
    clear_logs();
    device_present = 1'b0;
    send_start(2);
    wait_done(960 * C + 200, to);
    n_cmp++;
    if (to || done_q.size() != 1 || rise_q.size() != 1) begin
      n_bad++;
      $display("FAIL noprs_done_count: got %0d, expected 1", done_q.size());
    end else begin
      n_cmp++;
      if (done_q[0] - rise_q[0] != 960 * C) begin
        n_bad++;
        $display("FAIL noprs_done_time: got %0d, expected %0d", done_q[0] - rise_q[0], 960 * C);
      end
    end
    n_cmp++;
    if (presence_err !== 1'b1 || fetch_err !== 1'b0 || ren_rise_q.size() != 0) begin
      n_bad++;
      $display("FAIL noprs_flags: perr=%b ferr=%b fetches=%0d, expected 1 0 0",
               presence_err, fetch_err, ren_rise_q.size());
    end
    device_present = 1'b1;
  endtask

  task automatic test_fetch_timeout();
    bit to;
    clear_logs();
    dv_enable = 1'b0;
    send_start(2);
    wait_done(960 * C + 300, to);
    n_cmp++;
    if (to || done_q.size() != 1 || ren_len_q.size() != 1 || ren_fall_q.size() != 1) begin
      n_bad++;
      $display("FAIL timeout_done: dones=%0d fetches=%0d, expected 1 1", done_q.size(), ren_len_q.size());
    end else begin
      n_cmp++;
      if (ren_len_q[0] != 15) begin
        n_bad++;
        $display("FAIL timeout_read_en_len: got %0d, expected 15", ren_len_q[0]);
      end
      n_cmp++;
      if (done_q[0] != ren_fall_q[0]) begin
        n_bad++;
        $display("FAIL timeout_done_time: got %0d, expected %0d", done_q[0], ren_fall_q[0]);
      end
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (fetch_err !== 1'b1 || presence_err !== 1'b0 || ow_drive_low !== 1'b0 || low_q.size() != 1) begin
      n_bad++;
      $display("FAIL timeout_flags: ferr=%b perr=%b drive=%b lows=%0d, expected 1 0 0 1",
               fetch_err, presence_err, ow_drive_low, low_q.size());
    end
    dv_enable = 1'b1;
  endtask

  task automatic test_reset_mid_slot();
    bit to;
    bit seen;
    clear_logs();
    mem[0] = 8'h00;
    send_start(1);
    seen = 1'b0;
    for (int i = 0; i < 1200 * C; i++) begin
      @(negedge clk);
      if (low_q.size() >= 1 && ow_drive_low === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (!seen || ow_drive_low !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_state: slot_seen=%b drive=%b busy=%b done=%b, expected 1 0 0 0",
               seen, ow_drive_low, busy, done);
    end
    reset = 1'b0;
    repeat (300) @(negedge clk);
    n_cmp++;
    if (done_q.size() != 0) begin
      n_bad++;
      $display("FAIL midreset_no_done: got %0d, expected 0", done_q.size());
    end
    // Fresh frame after the interrupted one.
    clear_logs();
    mem[0] = 8'($urandom);
    send_start(1);
    wait_done(960 * C + 560 * C + 200, to);
    n_cmp++;
    if (to || done_q.size() != 1 || low_q.size() != 9) begin
      n_bad++;
      $display("FAIL midreset_refresh: dones=%0d lows=%0d, expected 1 9", done_q.size(), low_q.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        n_cmp++;
        if (low_q[1 + j] != (mem[0][j] ? 6 * C : 60 * C)) begin
          n_bad++;
          $display("FAIL midreset_bit[%0d]: got %0d, expected %0d", j, low_q[1 + j], mem[0][j] ? 6 * C : 60 * C);
        end
      end
    end
  endtask

  task automatic test_busy_ignore_zero_count();
    bit to;
    clear_logs();
    send_start(0);
    repeat (100) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_busy: got %b, expected 1", busy);
    end
    send_start(5);
    wait_done(960 * C + 300, to);
    n_cmp++;
    if (to || done_q.size() != 1 || rise_q.size() < 1) begin
      n_bad++;
      $display("FAIL zero_done_count: got %0d, expected 1", done_q.size());
    end else begin
      n_cmp++;
      if (done_q[0] - rise_q[0] != 960 * C) begin
        n_bad++;
        $display("FAIL zero_done_time: got %0d, expected %0d", done_q[0] - rise_q[0], 960 * C);
      end
    end
    repeat (100) @(negedge clk);
    n_cmp++;
    if (ren_rise_q.size() != 0 || low_q.size() != 1 || busy !== 1'b0 ||
        presence_err !== 1'b0 || fetch_err !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_after: fetches=%0d lows=%0d busy=%b perr=%b ferr=%b, expected 0 1 0 0 0",
               ren_rise_q.size(), low_q.size(), busy, presence_err, fetch_err);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    test_reset();
    test_frames();
    test_presence_err();
    test_fetch_timeout();
    test_reset_mid_slot();
    test_busy_ignore_zero_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
